// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator memory responder: data/address
// widths, matrix B base address, run-FSM state encoding and err bit indices.
`timescale 1ns/1ps
package accel_pkg;

   localparam int unsigned DW     = 64;   // four bf16 per word
   localparam int unsigned IN_AW  = 16;   // input memory: A low half, B high half
   localparam int unsigned RES_AW = 16;
   localparam int unsigned CNT_W  = 32;   // result-write counter width
   localparam int unsigned ERR_W  = 2;

   localparam logic [IN_AW-1:0] B_BASE = 16'h8000;

   // sticky error flag positions
   localparam int unsigned ERR_HOST_WR = 0;   // host write dropped outside IDLE
   localparam int unsigned ERR_TIMEOUT = 1;   // accelerator never finished

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_RUN       = 3'd3,
      ST_FIN       = 3'd4
   } run_state_e;

endpackage

// File: rtl/accel_dp_ram.sv
// One-write/one-read synchronous RAM, read-first, 1-cycle read latency.
// The read register only updates when re_i is high, so data holds otherwise.
// Ports:
//   clk, rst          clock, synchronous active-high reset (read register only)
//   we_i/waddr_i/wdata_i   write port
//   re_i/raddr_i/rdata_o   read port, rdata_o valid the cycle after re_i
`timescale 1ns/1ps
module accel_dp_ram #(
   parameter int unsigned AW = 16,
   parameter int unsigned DW = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   localparam int unsigned DEPTH = 2 ** AW;

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   // array is never reset; contents survive rst
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   // non-blocking read of the array yields the pre-write word on a collision
   always_ff @(posedge clk) begin
      if (rst)       rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/accel_mem_responder.sv
// Memory-side responder and run controller for the matmul accelerator.
// Serves the accelerator's input-memory reads, captures its result writes,
// gives the host a preload/drain port and sequences a run via comp_enb.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   mem_addr/mem_read_enb/mem_data   accelerator read port (enable active low)
//   res_addr/res_data/mem_write_enb  accelerator result write (enable active low)
//   comp_enb                         accelerator reset/start, high = held in reset
//   busyb, done                      accelerator status
//   host_we/host_waddr/host_wdata    host input-memory preload (IDLE only)
//   host_re/host_raddr/host_rdata/host_rvalid   host result drain
//   run_start/run_busy/run_done      run control
//   res_wr_count                     result writes seen this run (saturating)
//   err                              sticky [0] host write dropped, [1] timeout
`timescale 1ns/1ps
module accel_mem_responder
   import accel_pkg::*;
#(
   parameter int unsigned START_CYCLES = 2,
   parameter int unsigned TIMEOUT      = 1 << 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IN_AW-1:0]  mem_addr,
   input  logic              mem_read_enb,
   output logic [DW-1:0]     mem_data,
   input  logic [RES_AW-1:0] res_addr,
   input  logic [DW-1:0]     res_data,
   input  logic              mem_write_enb,
   output logic              comp_enb,
   input  logic              busyb,
   input  logic              done,
   input  logic              host_we,
   input  logic [IN_AW-1:0]  host_waddr,
   input  logic [DW-1:0]     host_wdata,
   input  logic              host_re,
   input  logic [RES_AW-1:0] host_raddr,
   output logic [DW-1:0]     host_rdata,
   output logic              host_rvalid,
   input  logic              run_start,
   output logic              run_busy,
   output logic              run_done,
   output logic [CNT_W-1:0]  res_wr_count,
   output logic [ERR_W-1:0]  err
);

   localparam int unsigned SCW = $clog2(START_CYCLES + 1);
   localparam int unsigned TW  = $clog2(TIMEOUT + 1);

   run_state_e       state_q, state_d;
   logic [SCW-1:0]   start_cnt_q, start_cnt_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             comp_enb_q, comp_enb_d;
   logic             run_busy_q, run_busy_d;
   logic             run_done_q, run_done_d;
   logic             host_rvalid_q;
   logic             timeout_c;
   logic             in_we_c;

   // host preload is only safe while the accelerator is idle
   assign in_we_c   = host_we && (state_q == ST_IDLE);
   assign timeout_c = (timer_q == TW'(TIMEOUT - 1));

   // input memory: host writes, accelerator reads
   accel_dp_ram #(.AW(IN_AW), .DW(DW)) u_in_mem (
      .clk     (clk),
      .rst     (rst),
      .we_i    (in_we_c),
      .waddr_i (host_waddr),
      .wdata_i (host_wdata),
      .re_i    (!mem_read_enb),
      .raddr_i (mem_addr),
      .rdata_o (mem_data)
   );

   // result memory: accelerator writes, host reads
   accel_dp_ram #(.AW(RES_AW), .DW(DW)) u_res_mem (
      .clk     (clk),
      .rst     (rst),
      .we_i    (!mem_write_enb),
      .waddr_i (res_addr),
      .wdata_i (res_data),
      .re_i    (host_re),
      .raddr_i (host_raddr),
      .rdata_o (host_rdata)
   );

   // run FSM next-state, counters and registered-output next values
   always_comb begin
      state_d     = state_q;
      start_cnt_d = start_cnt_q;
      timer_d     = timer_q;
      wr_cnt_d    = wr_cnt_q;
      err_d       = err_q;

      if (!mem_write_enb && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + 1'b1;
      if (host_we && (state_q != ST_IDLE))    err_d[ERR_HOST_WR] = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (run_start) begin
               state_d     = ST_START;
               start_cnt_d = '0;
               timer_d     = '0;
               wr_cnt_d    = '0;
               err_d       = '0;
            end
         end
         ST_START: begin
            if (start_cnt_q == SCW'(START_CYCLES - 1)) state_d = ST_WAIT_BUSY;
            else                                        start_cnt_d = start_cnt_q + 1'b1;
         end
         ST_WAIT_BUSY, ST_RUN: begin
            timer_d = timer_q + 1'b1;
            // done wins over a same-cycle timeout
            if (done) begin
               state_d = ST_FIN;
            end else if (timeout_c) begin
               state_d            = ST_FIN;
               err_d[ERR_TIMEOUT] = 1'b1;
            end else if ((state_q == ST_WAIT_BUSY) && busyb) begin
               state_d = ST_RUN;
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      comp_enb_d = (state_d == ST_IDLE) || (state_d == ST_START) || (state_d == ST_FIN);
      run_busy_d = (state_d == ST_START) || (state_d == ST_WAIT_BUSY) || (state_d == ST_RUN);
      run_done_d = (state_d == ST_FIN);
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         start_cnt_q   <= '0;
         timer_q       <= '0;
         wr_cnt_q      <= '0;
         err_q         <= '0;
         comp_enb_q    <= 1'b1;
         run_busy_q    <= 1'b0;
         run_done_q    <= 1'b0;
         host_rvalid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         start_cnt_q   <= start_cnt_d;
         timer_q       <= timer_d;
         wr_cnt_q      <= wr_cnt_d;
         err_q         <= err_d;
         comp_enb_q    <= comp_enb_d;
         run_busy_q    <= run_busy_d;
         run_done_q    <= run_done_d;
         host_rvalid_q <= host_re;
      end
   end

   assign comp_enb     = comp_enb_q;
   assign run_busy     = run_busy_q;
   assign run_done     = run_done_q;
   assign res_wr_count = wr_cnt_q;
   assign err          = err_q;
   assign host_rvalid  = host_rvalid_q;

endmodule

// File: doc/accel_mem_responder.md
Name: accel_mem_responder

Overview:
Memory-side responder and run controller for the matrix-multiply accelerator. It serves the accelerator's input-memory read port, which uses active-low read enable and returns 64-bit data. It captures the accelerator's result writes, which use active-low write enable, into a result buffer. It also gives the host a preload/drain port and a start/done run FSM that drives the accelerator's comp_enb.

Parameters:
IN_AW, 16, input-memory address width; matrix A at 0x0000-0x7FFF, matrix B at 0x8000-0xFFFF
RES_AW, 16, result-memory address width
DW, 64, data word width (four bf16 per word)
START_CYCLES, 2, cycles comp_enb is held high before release
TIMEOUT, 2^24, max cycles in WAIT_BUSY plus RUN before error

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_addr  in  IN_AW  accelerator read address
mem_read_enb  in  1  active-low read enable
mem_data  out  DW  read data
res_addr  in  RES_AW  accelerator write address
res_data  in  DW  accelerator write data
mem_write_enb  in  1  active-low write enable
comp_enb  out  1  accelerator reset/start (high = held in reset)
busyb  in  1  accelerator busy
done  in  1  accelerator done
host_we  in  1  host input-memory write strobe
host_waddr  in  IN_AW  host write address
host_wdata  in  DW  host write data
host_re  in  1  host result-memory read strobe
host_raddr  in  RES_AW  host read address
host_rdata  out  DW  host read data
host_rvalid  out  1  host read data valid
run_start  in  1  start pulse
run_busy  out  1  run in progress
run_done  out  1  one-cycle completion pulse
res_wr_count  out  32  result-write cycles counted in the current run
err  out  2  sticky: [0] host write rejected, [1] timeout

Behaviour:
- Reset values: mem_data=0, host_rdata=0, host_rvalid=0, comp_enb=1, run_busy=0, run_done=0, res_wr_count=0, err=0, FSM=IDLE. Memory contents are not cleared.
- Accelerator read:
  - Edge with mem_read_enb==0: mem_data <= in_mem[mem_addr]. Latency is 1 cycle.
  - mem_read_enb==1: mem_data holds its value.
- Accelerator write:
  - Edge with mem_write_enb==0: res_mem[res_addr] <= res_data, and res_wr_count increments (saturating).
  - Repeated writes to the same address overwrite; the last write wins.
- Host write:
  - Accepted only in IDLE; in_mem[host_waddr] <= host_wdata.
  - In any other state the write is dropped and err[0] is set.
- Host read:
  - Allowed in any state; host_rdata <= res_mem[host_raddr], host_rvalid=1 on the next cycle.
  - A same-cycle accelerator write to the same address returns the old data (read-first).
- FSM:
  - IDLE: comp_enb=1. run_start goes to START, clears res_wr_count and the count timer, and sets run_busy=1.
  - START: comp_enb=1 for START_CYCLES cycles, then drop comp_enb to 0 and go to WAIT_BUSY.
  - WAIT_BUSY: busyb==1 goes to RUN. done==1 seen here also goes directly to FIN.
  - RUN: done==1 goes to FIN.
  - FIN: comp_enb=1, run_done=1 for one cycle, run_busy=0, go to IDLE.
  - Timer: counts in WAIT_BUSY and RUN. Reaching TIMEOUT sets err[1] and goes to FIN, so run_done still pulses.
  - run_start outside IDLE is ignored.
  - err clears only on rst, or on run_start accepted in IDLE.
- rst mid-run: FSM returns to IDLE and comp_enb=1 in the following cycle, which forces the accelerator back to its reset state. run_done does not pulse.

Decomposition:
- Shared package accel_pkg holds:
  - DW, IN_AW, RES_AW
  - B_BASE=16'h8000
  - run-FSM state encoding IDLE/START/WAIT_BUSY/RUN/FIN
  - err bit indices
- One natural sub-module: accel_dp_ram, a one-write/one-read synchronous RAM with read-first behaviour and 1-cycle latency. It is instantiated twice: in_mem (write port = host, read port = accelerator) and res_mem (write port = accelerator, read port = host).

Test Plan:
- Read latency: host writes in_mem[0x8001]=64'h0102030405060708; drive mem_addr=0x8001, mem_read_enb=0 -> mem_data=64'h0102030405060708 exactly one cycle later. With mem_read_enb=1 and a new address -> mem_data unchanged.
- Result capture: mem_write_enb=0 for 3 cycles writing addr 5 = 64'hAA, then 64'hBB, then addr 6 = 64'hCC -> host read of 5 gives 64'hBB, read of 6 gives 64'hCC, host_rvalid 1 cycle after host_re, res_wr_count=3.
- Run handshake: run_start pulse -> comp_enb high for 2 cycles then 0; model raises busyb after 4 cycles and done after 100 -> run_done pulses once the cycle after done, comp_enb=1, run_busy=0.
- Host write during run: host_we in RUN -> in_mem unchanged, err[0]=1. Next run_start in IDLE -> err=0.
- Timeout (TIMEOUT=16 override): busyb and done never assert -> err[1]=1 at 16 cycles, run_done pulses, FSM in IDLE.
- Reset mid-run: rst asserted in RUN -> next cycle comp_enb=1, run_busy=0, run_done=0, res_wr_count=0, and res_mem contents are preserved.
